color_size_tx: RTL and testbench
================================

COLOR_SIZE_TX -- requirements
Module: color_size_tx

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 25, giving CLK cycles per serial half-period; legal range 1..255.
REQ-002 The block SHALL have port CLK  input  1  system clock; all logic is rising-edge.
REQ-003 The block SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port SEND  input  1  start request; sampled every CLK.
REQ-005 The block SHALL have port COLOR  input  4  color code, captured on acceptance.
REQ-006 The block SHALL have port SIZE  input  4  size code, captured on acceptance.
REQ-007 The block SHALL have port BUSY  output  1  high while a frame is in progress.
REQ-008 The block SHALL have port DONE  output  1  one-cycle pulse at frame completion.
REQ-009 The block SHALL have port TX_CLK  output  1  serial clock, drives receiver RCLK.
REQ-010 The block SHALL have port TX_DATA  output  1  serial data, drives receiver RDATA.
REQ-011 The block SHALL have port TX_RESET  output  1  frame-sync/reset, drives receiver RESET, active-high.

Function
REQ-012 Every output SHALL be driven directly from a register.
REQ-013 The FSM SHALL have states IDLE, SYNC, SHIFT and GAP.
REQ-014 One serial period SHALL be 2*CLK_DIV CLK cycles, timed by an 8-bit divider counter that restarts at every state entry.
REQ-015 In IDLE, SEND=1 SHALL be accepted: COLOR/SIZE latched into an 8-bit shift register {COLOR,SIZE}, transition to SYNC; BUSY=1 from the next cycle.
REQ-016 SEND while BUSY=1 SHALL be ignored; latched data SHALL NOT change during a frame.
REQ-017 SYNC SHALL last one serial period with TX_RESET=1, TX_CLK=0, TX_DATA=0, then go to SHIFT.
REQ-018 SHIFT SHALL send 8 bits MSB first (COLOR[3] first, SIZE[0] last), one bit per serial period.
REQ-019 Within each bit period, TX_DATA SHALL be valid from its first cycle; TX_CLK SHALL be 0 for the first CLK_DIV cycles and 1 for the last CLK_DIV cycles, so the receiver samples on the TX_CLK rising edge.
REQ-020 A 3-bit bit counter SHALL advance at the end of each bit period; after bit 7 the FSM SHALL go to GAP.
REQ-021 GAP SHALL last one serial period with TX_CLK=0, TX_DATA=0, TX_RESET=0, then return to IDLE.
REQ-022 On GAP->IDLE, DONE SHALL be 1 for exactly the first IDLE cycle and BUSY SHALL be 0 in that cycle.
REQ-023 SEND=1 in the DONE cycle SHALL be accepted, making back-to-back frames possible; the frame period is 20*CLK_DIV + 1 cycles.
REQ-024 The latency from the acceptance edge to the TX_RESET rise SHALL be 1 cycle; total frame length from the BUSY rise to the DONE pulse SHALL be 20*CLK_DIV cycles.
REQ-025 In IDLE, TX_CLK, TX_DATA and TX_RESET SHALL all be 0.

Reset
REQ-026 With RESET_N=0, without waiting for CLK, the block SHALL enter IDLE and set BUSY=0, DONE=0, TX_CLK=0, TX_DATA=0, TX_RESET=0, with all counters and the shift register at 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no DONE; after RESET_N rises the block SHALL wait in IDLE for a new SEND.
REQ-028 The first SEND SHALL be honoured on the first rising CLK edge after RESET_N deasserts.

Verification (CLK_DIV=2)
REQ-029 COLOR=4'b0011 and SIZE=4'b0001 with a 1-cycle SEND SHALL produce: TX_RESET high for 4 cycles; eight TX_CLK rising edges sampling TX_DATA as 0,0,1,1,0,0,0,1; DONE 40 cycles after the BUSY rise.
REQ-030 SEND pulsed again 10 cycles into a frame with different COLOR SHALL be ignored: the bit sequence stays unchanged and exactly one DONE is produced.
REQ-031 SEND held high continuously SHALL produce two back-to-back frames with exactly one IDLE cycle (the DONE cycle) between the GAP end and the next TX_RESET.
REQ-032 RESET_N pulled low during bit 4 SHALL force all outputs to 0 immediately with no DONE; after release, a new SEND with COLOR=4'b0101 and SIZE=4'b0010 SHALL transmit 0,1,0,1,0,0,1,0 correctly.
REQ-033 With CLK_DIV=1 and COLOR/SIZE=8'hFF, TX_CLK SHALL toggle every cycle through SHIFT, TX_DATA SHALL stay 1 for 16 cycles, and DONE SHALL follow 20 cycles after the BUSY rise.

Source files
------------

// File: rtl/color_size_tx.sv
// color_size_tx
//   Serialises an 8-bit {COLOR,SIZE} word to a simple three-wire receiver.
//   Each frame is a one-period sync pulse on TX_RESET, eight data bits sent
//   MSB first with TX_CLK rising mid-bit, and a one-period quiet gap.
//   One serial period is 2*CLK_DIV CLK cycles.
//
// Ports
//   CLK       in   system clock, rising edge
//   RESET_N   in   asynchronous active-low reset
//   SEND      in   start request, accepted only when idle
//   COLOR     in   [3:0] color code, captured on acceptance
//   SIZE      in   [3:0] size code, captured on acceptance
//   BUSY      out  frame in progress
//   DONE      out  one-cycle pulse on return to idle
//   TX_CLK    out  serial clock to receiver RCLK
//   TX_DATA   out  serial data to receiver RDATA
//   TX_RESET  out  frame sync to receiver RESET, active high
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for SEND; all serial lines low
// SYNC  | one serial period with TX_RESET high
// SHIFT | eight bit periods, TX_CLK low then high within each
// GAP   | one serial period with all serial lines low, then DONE

module color_size_tx #(
    parameter int CLK_DIV = 25
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       SEND,
    input  logic [3:0] COLOR,
    input  logic [3:0] SIZE,
    output logic       BUSY,
    output logic       DONE,
    output logic       TX_CLK,
    output logic       TX_DATA,
    output logic       TX_RESET
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    // The divider counts one half-period (CLK_DIV cycles) down to zero and
    // a phase bit selects the first or second half, so the counter stays
    // 8 bits wide even for CLK_DIV = 255.
    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

    state_t      state, state_nxt;
    logic [7:0]  div_cnt, div_cnt_nxt;
    logic        half, half_nxt;
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic        busy_nxt, done_nxt, tx_clk_nxt, tx_data_nxt, tx_reset_nxt;

    logic        half_end;
    logic        period_end;
    logic [2:0]  bit_inc;

    assign half_end   = !half && (div_cnt == 8'd0);
    assign period_end =  half && (div_cnt == 8'd0);
    assign bit_inc    = bit_cnt + 3'd1;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            div_cnt  <= 8'd0;
            half     <= 1'b0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'd0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            TX_CLK   <= 1'b0;
            TX_DATA  <= 1'b0;
            TX_RESET <= 1'b0;
        end else begin
            state    <= state_nxt;
            div_cnt  <= div_cnt_nxt;
            half     <= half_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
            BUSY     <= busy_nxt;
            DONE     <= done_nxt;
            TX_CLK   <= tx_clk_nxt;
            TX_DATA  <= tx_data_nxt;
            TX_RESET <= tx_reset_nxt;
        end
    end

    // Outputs are computed one cycle ahead so that every port comes straight
    // from a flop and changes on the same edge as the state it belongs to.
    always_comb begin
        state_nxt    = state;
        div_cnt_nxt  = div_cnt;
        half_nxt     = half;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        busy_nxt     = BUSY;
        done_nxt     = 1'b0;
        tx_clk_nxt   = TX_CLK;
        tx_data_nxt  = TX_DATA;
        tx_reset_nxt = TX_RESET;

        if (state != IDLE) begin
            if (div_cnt != 8'd0) begin
                div_cnt_nxt = div_cnt - 8'd1;
            end else begin
                div_cnt_nxt = DIV_LOAD;
                half_nxt    = ~half;
            end
        end

        unique case (state)
            IDLE: begin
                busy_nxt     = 1'b0;
                tx_clk_nxt   = 1'b0;
                tx_data_nxt  = 1'b0;
                tx_reset_nxt = 1'b0;
                if (SEND) begin
                    state_nxt    = SYNC;
                    shreg_nxt    = {COLOR, SIZE};
                    busy_nxt     = 1'b1;
                    tx_reset_nxt = 1'b1;
                    div_cnt_nxt  = DIV_LOAD;
                    half_nxt     = 1'b0;
                    bit_cnt_nxt  = 3'd0;
                end
            end

            SYNC: begin
                if (period_end) begin
                    state_nxt    = SHIFT;
                    tx_reset_nxt = 1'b0;
                    tx_data_nxt  = shreg[7];
                    div_cnt_nxt  = DIV_LOAD;
                    half_nxt     = 1'b0;
                    bit_cnt_nxt  = 3'd0;
                end
            end

            SHIFT: begin
                if (half_end) begin
                    tx_clk_nxt = 1'b1;
                end
                if (period_end) begin
                    tx_clk_nxt  = 1'b0;
                    div_cnt_nxt = DIV_LOAD;
                    half_nxt    = 1'b0;
                    if (bit_cnt == 3'd7) begin
                        state_nxt   = GAP;
                        tx_data_nxt = 1'b0;
                        bit_cnt_nxt = 3'd0;
                    end else begin
                        bit_cnt_nxt = bit_inc;
                        // bit k of the frame is shreg[7-k]; 7-k == ~k in 3 bits
                        tx_data_nxt = shreg[~bit_inc];
                    end
                end
            end

            GAP: begin
                if (period_end) begin
                    state_nxt   = IDLE;
                    busy_nxt    = 1'b0;
                    done_nxt    = 1'b1;
                    div_cnt_nxt = 8'd0;
                    half_nxt    = 1'b0;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_color_size_tx.sv
module tb_color_size_tx;

    localparam int D = 2;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       SEND;
    logic [3:0] COLOR, SIZE;
    logic       BUSY, DONE, TX_CLK, TX_DATA, TX_RESET;

    logic       send1;
    logic [3:0] color1, size1;
    logic       busy1, done1, tx_clk1, tx_data1, tx_reset1;

    always #5 CLK = ~CLK;

    color_size_tx #(.CLK_DIV(D)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .SEND(SEND), .COLOR(COLOR), .SIZE(SIZE),
        .BUSY(BUSY), .DONE(DONE), .TX_CLK(TX_CLK), .TX_DATA(TX_DATA), .TX_RESET(TX_RESET)
    );

    color_size_tx #(.CLK_DIV(1)) dut1 (
        .CLK(CLK), .RESET_N(RESET_N), .SEND(send1), .COLOR(color1), .SIZE(size1),
        .BUSY(busy1), .DONE(done1), .TX_CLK(tx_clk1), .TX_DATA(tx_data1), .TX_RESET(tx_reset1)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    int n_push = 0;
    int n_done = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the receiver should see exactly the 8-bit word, MSB first,
    // sampled on TX_CLK rising edges; frame = 20*D busy cycles then DONE.
    int         cyc = 0;
    int         busy_start = 0;
    int         last_done_cyc = -1000;
    int         b2b_gap = -1;
    int         rst_len = 0;
    int         nbits = 0;
    logic [7:0] bits = 8'd0;
    logic       p_busy = 0, p_txr = 0, p_txclk = 0, p_done = 0;

    always @(negedge CLK) begin
        cyc++;
        if (!RESET_N) begin
            nbits = 0; bits = 8'd0; rst_len = 0;
            p_busy = 0; p_txr = 0; p_txclk = 0; p_done = 0;
        end else begin
            if (BUSY && !p_busy) busy_start = cyc;
            if (TX_RESET) begin
                if (!p_txr) b2b_gap = cyc - last_done_cyc;
                rst_len++;
            end else if (p_txr) begin
                check("sync_len", rst_len, 2 * D);
                rst_len = 0;
                nbits = 0;
            end
            if (TX_CLK && !p_txclk) begin
                bits = {bits[6:0], TX_DATA};
                nbits++;
            end
            if (!BUSY) check("idle_lines", {29'd0, TX_CLK, TX_DATA, TX_RESET}, 0);
            if (DONE) begin
                n_done++;
                last_done_cyc = cyc;
                check("done_pulse_width", int'(p_done), 0);
                check("busy_in_done", int'(BUSY), 0);
                check("frame_len", cyc - busy_start, 20 * D);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: DONE with no frame pending at %0t", $time);
                end else begin
                    logic [7:0] exp_w;
                    exp_w = q.pop_front();
                    check("bit_count", nbits, 8);
                    check("frame_bits", int'(bits), int'(exp_w));
                end
            end
            p_busy = BUSY; p_txr = TX_RESET; p_txclk = TX_CLK; p_done = DONE;
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (BUSY !== 1'b0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) check("wait_idle_timeout", 1, 0);
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (n_done < target && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 300) check("wait_done_timeout", n_done, target);
    endtask

    task automatic send_frame(input logic [3:0] c, input logic [3:0] s);
        wait_idle();
        COLOR = c; SIZE = s; SEND = 1'b1;
        q.push_back({c, s});
        n_push++;
        @(negedge CLK);
        SEND = 1'b0;
    endtask

    initial begin
        RESET_N = 1'b0;
        SEND = 1'b1; COLOR = 4'b0011; SIZE = 4'b0001;
        send1 = 1'b0; color1 = 4'h0; size1 = 4'h0;
        repeat (3) @(negedge CLK);
        #1;
        check("rst_busy", int'(BUSY), 0);
        check("rst_done", int'(DONE), 0);
        check("rst_lines", {29'd0, TX_CLK, TX_DATA, TX_RESET}, 0);

        // first SEND honoured on the first edge after reset release
        q.push_back(8'h31);
        n_push++;
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        check("first_accept_busy", int'(BUSY), 1);
        check("first_accept_txreset", int'(TX_RESET), 1);
        @(negedge CLK);
        SEND = 1'b0;
        wait_done(n_push);

        // SEND during a frame with different data is ignored
        send_frame(4'hA, 4'h6);
        repeat (9) @(negedge CLK);
        COLOR = 4'h5; SIZE = 4'h9; SEND = 1'b1;
        @(negedge CLK);
        SEND = 1'b0;
        wait_done(n_push);
        repeat (45) @(negedge CLK);
        check("single_done", n_done, n_push);

        // random frames, random spacing, random ignored requests
        for (int i = 0; i < 8; i++) begin
            int gap;
            int k;
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge CLK);
            send_frame(4'($urandom), 4'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(1, 30);
                repeat (k) @(negedge CLK);
                COLOR = 4'($urandom); SIZE = 4'($urandom); SEND = 1'b1;
                @(negedge CLK);
                SEND = 1'b0;
            end
            wait_done(n_push);
        end

        // SEND held high: back-to-back frames, one idle (DONE) cycle between
        wait_idle();
        COLOR = 4'hC; SIZE = 4'h3; SEND = 1'b1;
        q.push_back(8'hC3); n_push++;
        @(negedge CLK);
        COLOR = 4'h6; SIZE = 4'h9;
        q.push_back(8'h69); n_push++;
        repeat (59) @(negedge CLK);
        SEND = 1'b0;
        wait_done(n_push);
        check("b2b_idle_gap", b2b_gap, 1);

        // reset during bit 4 aborts the frame without DONE
        send_frame(4'hE, 4'h7);
        repeat (21) @(negedge CLK);
        #2;
        RESET_N = 1'b0;
        #1;
        check("abort_busy", int'(BUSY), 0);
        check("abort_lines", {29'd0, DONE, TX_CLK, TX_DATA, TX_RESET}, 0);
        q.delete();
        n_push--;
        repeat (3) @(negedge CLK);
        #2;
        RESET_N = 1'b1;
        repeat (6) @(negedge CLK);
        check("abort_no_done", n_done, n_push);
        check("abort_idle", int'(BUSY), 0);
        send_frame(4'b0101, 4'b0010);
        wait_done(n_push);

        // CLK_DIV = 1 instance, all-ones word
        begin
            int ones;
            ones = 0;
            @(negedge CLK);
            color1 = 4'hF; size1 = 4'hF; send1 = 1'b1;
            @(negedge CLK);
            send1 = 1'b0;
            for (int i = 0; i < 20; i++) begin
                check("d1_busy", int'(busy1), 1);
                check("d1_txreset", int'(tx_reset1), (i < 2) ? 1 : 0);
                check("d1_txclk", int'(tx_clk1), (i >= 2 && i < 18) ? ((i - 2) % 2) : 0);
                if (tx_data1) ones++;
                @(negedge CLK);
            end
            check("d1_data_ones", ones, 16);
            check("d1_done", int'(done1), 1);
            check("d1_done_busy", int'(busy1), 0);
        end

        repeat (5) @(negedge CLK);
        check("final_queue_empty", q.size(), 0);
        check("final_done_count", n_done, n_push);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
